// File: rtl/mux_scan_ctrl.sv
// Sequences an 8x1 analog/digital mux through all channels, settling each before sampling,
// and publishes the full 8-bit snapshot only once the whole scan has completed.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic [7:0] data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StFin} state_t;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYC);

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            k_q      <= 3'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 8'h00;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                k_d = 3'd0;
                // start takes priority over a simultaneous abort here
                if (start) begin
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                    busy_d  = 1'b1;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    k_d     = 3'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = StSample;
                    end
                end
            end
            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                    k_d     = 3'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                end else begin
                    shadow_d[k_q] = mux_out;
                    if (k_q == 3'd7) begin
                        // publish including the channel-7 bit captured on this same edge
                        state_d = StFin;
                        data_d  = shadow_d;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StSettle;
                        k_d     = k_q + 3'd1;
                        cnt_d   = SettleLoad;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                k_d     = 3'd0;
            end
            default: begin
                state_d = StIdle;
                k_d     = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign {s2, s1, s0} = k_q;
    assign data         = data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: cycle-accurate expectations derived from the scan
// timeline (channel = elapsed/(settle+1)), with randomized mux contents and abort points.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_drv = 1'b0;
    logic abort_drv = 1'b0;
    logic use3 = 1'b0;
    logic [7:0] pat = 8'h00;

    int checks = 0;
    int passes = 0;
    logic [7:0] prev1 = 8'h00;
    logic [7:0] prev3 = 8'h00;

    always #5 clk = ~clk;

    logic s0_1, s1_1, s2_1, busy_1, done_1, mux_out1, start1, abort1;
    logic s0_3, s1_3, s2_3, busy_3, done_3, mux_out3, start3, abort3;
    logic [7:0] data_1, data_3;

    assign start1   = start_drv & ~use3;
    assign abort1   = abort_drv & ~use3;
    assign start3   = start_drv & use3;
    assign abort3   = abort_drv & use3;
    assign mux_out1 = pat[{s2_1, s1_1, s0_1}];
    assign mux_out3 = pat[{s2_3, s1_3, s0_3}];

    mux_scan_ctrl #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mux_out(mux_out1),
        .s0(s0_1), .s1(s1_1), .s2(s2_1), .data(data_1), .busy(busy_1), .done(done_1)
    );

    mux_scan_ctrl #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .mux_out(mux_out3),
        .s0(s0_3), .s1(s1_3), .s2(s2_3), .data(data_3), .busy(busy_3), .done(done_3)
    );

    // observed vector {sel, busy, done, data} of the DUT currently under test
    logic [12:0] obs1, obs3, obs;
    assign obs1 = {s2_1, s1_1, s0_1, busy_1, done_1, data_1};
    assign obs3 = {s2_3, s1_3, s0_3, busy_3, done_3, data_3};
    assign obs  = use3 ? obs3 : obs1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full scan started just after edge E0; start is seen at E0+1, DONE expected at
    // E0 + 8*(settle+1) + 1, then one cycle later back in idle.
    task automatic do_scan(input logic [7:0] p, input string name);
        int s;
        int len;
        logic [7:0] prev;
        logic [12:0] exp_v;
        logic [2:0] sel;
        s    = use3 ? 3 : 1;
        len  = 8 * (s + 1);
        prev = use3 ? prev3 : prev1;
        pat  = p;
        start_drv = 1'b1;
        for (int n = 1; n <= len + 2; n++) begin
            step();
            if (n == 1) start_drv = 1'b0;
            if (n <= len) begin
                sel   = 3'((n - 1) / (s + 1));
                exp_v = {sel, 1'b1, 1'b0, prev};
            end else if (n == len + 1) begin
                exp_v = {3'd7, 1'b0, 1'b1, p};
            end else begin
                exp_v = {3'd0, 1'b0, 1'b0, p};
            end
            checks++;
            if (obs !== exp_v)
                $display("FAIL %s cycle E0+%0d got sel/busy/done/data=%h required=%h",
                         name, n, obs, exp_v);
            else
                passes++;
        end
        if (use3) prev3 = p;
        else prev1 = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs1 !== 13'd0 || obs3 !== 13'd0)
            $display("FAIL reset_values got %h/%h required 0/0", obs1, obs3);
        else
            passes++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (obs1 !== 13'd0)
            $display("FAIL reset_idle got %h required 0", obs1);
        else
            passes++;
    endtask

    task automatic test_basic();
        use3 = 1'b0;
        do_scan(8'h55, "basic_scan");
    endtask

    task automatic test_abort();
        int k;
        int n_ab;
        int done_seen;
        logic [12:0] exp_v;
        for (int it = 0; it < 3; it++) begin
            k    = (it == 0) ? 4 : int'($urandom_range(0, 7));
            n_ab = k * 2 + 1 + int'($urandom_range(0, 1));
            pat  = 8'($urandom);
            start_drv = 1'b1;
            for (int n = 1; n <= n_ab; n++) begin
                step();
                if (n == 1) start_drv = 1'b0;
                exp_v = {3'((n - 1) / 2), 1'b1, 1'b0, prev1};
                checks++;
                if (obs !== exp_v)
                    $display("FAIL abort_prefix cycle %0d got %h required %h", n, obs, exp_v);
                else
                    passes++;
            end
            abort_drv = 1'b1;
            step();
            abort_drv = 1'b0;
            checks++;
            if (obs !== {3'd0, 1'b0, 1'b0, prev1})
                $display("FAIL abort_k%0d got %h required %h", k, obs, {3'd0, 2'b00, prev1});
            else
                passes++;
            done_seen = 0;
            for (int n = 0; n < 20; n++) begin
                step();
                if (done_1 !== 1'b0 || busy_1 !== 1'b0) done_seen++;
            end
            checks++;
            if (done_seen != 0)
                $display("FAIL abort_no_done got %0d active cycles required 0", done_seen);
            else
                passes++;
        end
        // abort alone in idle does nothing; abort with start in idle lets start win
        abort_drv = 1'b1;
        step();
        checks++;
        if (obs !== {3'd0, 1'b0, 1'b0, prev1})
            $display("FAIL abort_in_idle got %h required %h", obs, {3'd0, 2'b00, prev1});
        else
            passes++;
        start_drv = 1'b1;
        step();
        start_drv = 1'b0;
        checks++;
        if (obs !== {3'd0, 1'b1, 1'b0, prev1})
            $display("FAIL start_beats_abort got %h required %h", obs, {3'd0, 2'b10, prev1});
        else
            passes++;
        step();
        abort_drv = 1'b0;
        checks++;
        if (obs !== {3'd0, 1'b0, 1'b0, prev1})
            $display("FAIL abort_in_settle got %h required %h", obs, {3'd0, 2'b00, prev1});
        else
            passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [3];
        logic [7:0] cur_prev;
        logic [12:0] exp_v;
        int scan;
        int p;
        int dones;
        for (int i = 0; i < 3; i++) pats[i] = 8'($urandom);
        pat   = pats[0];
        dones = 0;
        start_drv = 1'b1;
        for (int n = 1; n <= 3 * 18 - 1; n++) begin
            step();
            scan     = (n - 1) / 18;
            p        = (n - 1) % 18;
            cur_prev = (scan == 0) ? prev1 : pats[scan - 1];
            if (p < 16)       exp_v = {3'(p / 2), 1'b1, 1'b0, cur_prev};
            else if (p == 16) exp_v = {3'd7, 1'b0, 1'b1, pats[scan]};
            else              exp_v = {3'd0, 1'b0, 1'b0, pats[scan]};
            if (done_1 === 1'b1) dones++;
            checks++;
            if (obs !== exp_v)
                $display("FAIL back_to_back cycle %0d got %h required %h", n, obs, exp_v);
            else
                passes++;
            if (p == 17 && scan < 2) pat = pats[scan + 1];
        end
        start_drv = 1'b0;
        step();
        step();
        checks++;
        if (obs !== {3'd0, 1'b0, 1'b0, pats[2]} || dones != 3)
            $display("FAIL back_to_back_end got %h dones=%0d required %h dones=3",
                     obs, dones, {3'd0, 2'b00, pats[2]});
        else
            passes++;
        prev1 = pats[2];
    endtask

    task automatic test_async_reset();
        int n_rst;
        logic [12:0] exp_v;
        n_rst = 3 * 2 + 1 + int'($urandom_range(0, 1));
        pat   = 8'($urandom);
        start_drv = 1'b1;
        for (int n = 1; n <= n_rst; n++) begin
            step();
            if (n == 1) start_drv = 1'b0;
            exp_v = {3'((n - 1) / 2), 1'b1, 1'b0, prev1};
            checks++;
            if (obs !== exp_v)
                $display("FAIL rst_prefix cycle %0d got %h required %h", n, obs, exp_v);
            else
                passes++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs1 !== 13'd0 || obs3 !== 13'd0)
            $display("FAIL async_reset got %h/%h required 0/0", obs1, obs3);
        else
            passes++;
        #1;
        rst_n = 1'b1;
        prev1 = 8'h00;
        prev3 = 8'h00;
        do_scan(8'($urandom), "scan_after_reset");
    endtask

    task automatic test_settle3();
        use3 = 1'b1;
        do_scan(8'hF0, "settle3_scan");
        do_scan(8'($urandom), "settle3_random");
        use3 = 1'b0;
    endtask

    task automatic test_random_scans();
        int gap;
        for (int i = 0; i < 4; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step();
                checks++;
                if (obs !== {3'd0, 1'b0, 1'b0, prev1})
                    $display("FAIL random_gap got %h required %h", obs, {3'd0, 2'b00, prev1});
                else
                    passes++;
            end
            do_scan(8'($urandom), "random_scan");
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_settle3();
        test_random_scans();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
